// File: rtl/axi_defines_pkg.sv
// Shared AXI constants, FSM encodings and size helpers for the burst splitter.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package axi_defines;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam int unsigned AXI_FIXED_MAX_LEN = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // AXSIZE encoding for a data bus of dw bits
    function automatic logic [2:0] axi_size(input int unsigned dw);
        return 3'(`CLOG2(dw / 8));
    endfunction

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned umin(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_splitter_if.sv
// Command and burst-descriptor signals between the user front end and the AW/AR issue logic.
interface axi_burst_splitter_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 24,
    parameter int unsigned ID_WIDTH    = 4
);
    logic                   i_cmd_en;
    logic [ADDR_WIDTH-1:0]  i_cmd_addr;
    logic [COUNT_WIDTH-1:0] i_cmd_count;
    logic                   i_cmd_wr_rd;
    logic                   i_cmd_adr_fixed_en;
    logic                   o_cmd_ack;
    logic                   o_cmd_error;
    logic                   o_busy;
    logic                   o_bst_valid;
    logic                   i_bst_ready;
    logic [ADDR_WIDTH-1:0]  o_bst_addr;
    logic [7:0]             o_bst_len;
    logic [2:0]             o_bst_size;
    logic [1:0]             o_bst_burst;
    logic                   o_bst_wr_rd;
    logic [ID_WIDTH-1:0]    o_bst_id;
    logic                   o_bst_last;

    // Splitter side: consumes commands, masters the burst descriptor channel
    modport master (
        input  i_cmd_en, i_cmd_addr, i_cmd_count, i_cmd_wr_rd, i_cmd_adr_fixed_en, i_bst_ready,
        output o_cmd_ack, o_cmd_error, o_busy, o_bst_valid, o_bst_addr, o_bst_len,
               o_bst_size, o_bst_burst, o_bst_wr_rd, o_bst_id, o_bst_last
    );

    modport slave (
        output i_cmd_en, i_cmd_addr, i_cmd_count, i_cmd_wr_rd, i_cmd_adr_fixed_en, i_bst_ready,
        input  o_cmd_ack, o_cmd_error, o_busy, o_bst_valid, o_bst_addr, o_bst_len,
               o_bst_size, o_bst_burst, o_bst_wr_rd, o_bst_id, o_bst_last
    );
endinterface

// File: rtl/axi_burst_splitter_calc.sv
// Combinational beats-per-burst: min of remaining, burst cap and distance to the next boundary.
module axi_burst_calc
    import axi_defines::*;
#(
    parameter int unsigned COUNT_WIDTH   = 24,
    parameter int unsigned MAX_BURST_LEN = 256,
    parameter int unsigned BOUNDARY      = 4096,
    parameter int unsigned BPB           = 4
) (
    input  logic [$clog2(BOUNDARY)-1:0] addr,
    input  logic [COUNT_WIDTH-1:0]      remaining,
    input  logic                        fixed,
    output logic [COUNT_WIDTH:0]        beats
);
    localparam int unsigned BND_W   = $clog2(BOUNDARY);
    localparam int unsigned LSB     = $clog2(BPB);
    localparam int unsigned CW      = umax(umax(COUNT_WIDTH + 1, BND_W + 1), 10);
    localparam int unsigned FIX_CAP = umin(AXI_FIXED_MAX_LEN, MAX_BURST_LEN);

    logic [CW-1:0] bnd_bytes;
    logic [CW-1:0] bnd_beats;
    logic [CW-1:0] cap;
    logic [CW-1:0] min_v;

    // addr holds only the offset inside the current boundary window
    assign bnd_bytes = CW'(BOUNDARY) - CW'(addr);
    assign bnd_beats = bnd_bytes >> LSB;
    assign cap       = fixed ? CW'(FIX_CAP) : CW'(MAX_BURST_LEN);

    always_comb begin
        min_v = (CW'(remaining) < cap) ? CW'(remaining) : cap;
        if (!fixed && (bnd_beats < min_v)) begin
            min_v = bnd_beats;
        end
        beats = (COUNT_WIDTH + 1)'(min_v);
    end
endmodule

// File: rtl/axi_burst_splitter.sv
// Splits one user transfer command into legal AXI burst descriptors with round-robin IDs.
module axi_burst_splitter
    import axi_defines::*;
#(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned COUNT_WIDTH   = 24,
    parameter int unsigned MAX_BURST_LEN = 256,
    parameter int unsigned BOUNDARY      = 4096,
    parameter int unsigned ID_WIDTH      = 4,
    parameter int unsigned NUM_IDS       = 4
) (
    input logic              clk,
    input logic              rst,
    axi_burst_splitter_if.master bus
);
    localparam int unsigned BPB   = DATA_WIDTH / 8;
    localparam int unsigned LSB   = $clog2(BPB);
    localparam int unsigned BND_W = $clog2(BOUNDARY);
    localparam int unsigned BW    = COUNT_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BPB - 1);
    localparam logic [2:0] SIZE = axi_size(DATA_WIDTH);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic [BW-1:0]          beats_q, beats_d, beats_c;
    logic                   fixed_q, fixed_d, wr_q, wr_d, err_q, err_d;
    logic [ID_WIDTH-1:0]    id_q, id_d;

    logic                   ack_q, ack_d, error_q, error_d, busy_q, busy_d;
    logic                   valid_q, valid_d, bwr_q, bwr_d, last_q, last_d;
    logic [ADDR_WIDTH-1:0]  baddr_q, baddr_d;
    logic [7:0]             len_q, len_d;
    logic [1:0]             burst_q, burst_d;
    logic [ID_WIDTH-1:0]    bid_q, bid_d;

    axi_burst_calc #(
        .COUNT_WIDTH   (COUNT_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN),
        .BOUNDARY      (BOUNDARY),
        .BPB           (BPB)
    ) u_calc (
        .addr      (addr_q[BND_W-1:0]),
        .remaining (rem_q),
        .fixed     (fixed_q),
        .beats     (beats_c)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        beats_d = beats_q;
        fixed_d = fixed_q;
        wr_d    = wr_q;
        err_d   = err_q;
        id_d    = id_q;
        ack_d   = ack_q;
        error_d = error_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        baddr_d = baddr_q;
        len_d   = len_q;
        burst_d = burst_q;
        bwr_d   = bwr_q;
        bid_d   = bid_q;
        last_d  = last_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_cmd_en) begin
                    addr_d  = bus.i_cmd_addr & ALIGN_MASK;
                    rem_d   = bus.i_cmd_count;
                    fixed_d = bus.i_cmd_adr_fixed_en;
                    wr_d    = bus.i_cmd_wr_rd;
                    busy_d  = 1'b1;
                    err_d   = (bus.i_cmd_count == '0);
                    state_d = (bus.i_cmd_count == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                baddr_d = addr_q;
                len_d   = 8'(beats_c - BW'(1));
                burst_d = fixed_q ? AXI_BURST_FIXED : AXI_BURST_INCR;
                bwr_d   = wr_q;
                bid_d   = id_q;
                last_d  = (beats_c == BW'(rem_q));
                beats_d = beats_c;
                valid_d = 1'b1;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                // last_q marks the burst that drains remaining to zero
                if (bus.i_bst_ready) begin
                    valid_d = 1'b0;
                    rem_d   = rem_q - COUNT_WIDTH'(beats_q);
                    if (!fixed_q) begin
                        addr_d = addr_q + (ADDR_WIDTH'(beats_q) << LSB);
                    end
                    id_d    = (id_q == ID_WIDTH'(NUM_IDS - 1)) ? '0 : id_q + ID_WIDTH'(1);
                    state_d = last_q ? ST_DONE : ST_CALC;
                end
            end
            ST_DONE: begin
                if (bus.i_cmd_en) begin
                    ack_d   = 1'b1;
                    error_d = err_q;
                end else begin
                    ack_d   = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            beats_q <= '0;
            fixed_q <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            id_q    <= '0;
            ack_q   <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            baddr_q <= '0;
            len_q   <= '0;
            burst_q <= '0;
            bwr_q   <= 1'b0;
            bid_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            beats_q <= beats_d;
            fixed_q <= fixed_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            id_q    <= id_d;
            ack_q   <= ack_d;
            error_q <= error_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            baddr_q <= baddr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            bwr_q   <= bwr_d;
            bid_q   <= bid_d;
            last_q  <= last_d;
        end
    end

    assign bus.o_cmd_ack   = ack_q;
    assign bus.o_cmd_error = error_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_bst_valid = valid_q;
    assign bus.o_bst_addr  = baddr_q;
    assign bus.o_bst_len   = len_q;
    assign bus.o_bst_size  = SIZE;
    assign bus.o_bst_burst = burst_q;
    assign bus.o_bst_wr_rd = bwr_q;
    assign bus.o_bst_id    = bid_q;
    assign bus.o_bst_last  = last_q;
endmodule

// File: tb/tb_axi_burst_splitter.sv
// Directed bench for axi_burst_splitter with DATA_WIDTH 32, 4 KiB boundary and 4 IDs.
module tb_axi_burst_splitter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   hs_count = 0;
    int   hs_before;

    axi_burst_splitter_if #(.ADDR_WIDTH(32), .COUNT_WIDTH(24), .ID_WIDTH(4)) bus ();

    axi_burst_splitter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .COUNT_WIDTH(24), .MAX_BURST_LEN(256),
        .BOUNDARY(4096), .ID_WIDTH(4), .NUM_IDS(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.o_bst_valid && bus.i_bst_ready) hs_count <= hs_count + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] addr, input logic [23:0] count,
                        input logic wr, input logic fixed);
        bus.i_cmd_addr         = addr;
        bus.i_cmd_count        = count;
        bus.i_cmd_wr_rd        = wr;
        bus.i_cmd_adr_fixed_en = fixed;
        bus.i_cmd_en           = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (bus.o_bst_valid) break;
            step();
        end
        chk({tag, "_valid"}, 64'(bus.o_bst_valid), 64'd1);
    endtask

    task automatic wait_ack(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (bus.o_cmd_ack) break;
            step();
        end
        chk({tag, "_ack"}, 64'(bus.o_cmd_ack), 64'd1);
    endtask

    task automatic burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] bt, input logic [3:0] id, input logic last,
                         input logic wr);
        chk({tag, "_addr"},  64'(bus.o_bst_addr),  64'(addr));
        chk({tag, "_len"},   64'(bus.o_bst_len),   64'(len));
        chk({tag, "_burst"}, 64'(bus.o_bst_burst), 64'(bt));
        chk({tag, "_id"},    64'(bus.o_bst_id),    64'(id));
        chk({tag, "_last"},  64'(bus.o_bst_last),  64'(last));
        chk({tag, "_wr"},    64'(bus.o_bst_wr_rd), 64'(wr));
        chk({tag, "_size"},  64'(bus.o_bst_size),  64'd2);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_valid"}, 64'(bus.o_bst_valid), 64'd0);
        chk({tag, "_ack"},   64'(bus.o_cmd_ack),   64'd0);
        chk({tag, "_err"},   64'(bus.o_cmd_error), 64'd0);
        chk({tag, "_busy"},  64'(bus.o_busy),      64'd0);
        chk({tag, "_addr"},  64'(bus.o_bst_addr),  64'd0);
        chk({tag, "_len"},   64'(bus.o_bst_len),   64'd0);
        chk({tag, "_id"},    64'(bus.o_bst_id),    64'd0);
        chk({tag, "_last"},  64'(bus.o_bst_last),  64'd0);
        chk({tag, "_size"},  64'(bus.o_bst_size),  64'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_cmd_en = 1'b0;
        bus.i_cmd_addr = '0;
        bus.i_cmd_count = '0;
        bus.i_cmd_wr_rd = 1'b0;
        bus.i_cmd_adr_fixed_en = 1'b0;
        bus.i_bst_ready = 1'b1;

        // Reset values
        step(); step();
        all_zero("reset");
        rst = 1'b0;
        step();

        // Boundary split: 0xFF0 + 10 beats -> 4 beats then 6 beats
        send(32'h0FF0, 24'd10, 1'b1, 1'b0);
        step();
        chk("lat_busy", 64'(bus.o_busy), 64'd1);
        chk("lat_n1_valid", 64'(bus.o_bst_valid), 64'd0);
        step();
        chk("lat_n2_valid", 64'(bus.o_bst_valid), 64'd1);
        burst("b1", 32'h0FF0, 8'd3, 2'd1, 4'd0, 1'b0, 1'b1);
        step();
        chk("b1_gap_valid", 64'(bus.o_bst_valid), 64'd0);
        step();
        chk("b2_valid", 64'(bus.o_bst_valid), 64'd1);
        burst("b2", 32'h1000, 8'd5, 2'd1, 4'd1, 1'b1, 1'b1);
        step();
        wait_ack("cmd1");
        chk("cmd1_err", 64'(bus.o_cmd_error), 64'd0);
        bus.i_cmd_en = 1'b0;
        step();
        chk("cmd1_ack_clr", 64'(bus.o_cmd_ack), 64'd0);
        chk("cmd1_busy_clr", 64'(bus.o_busy), 64'd0);

        // 600 beats from 0: max-length bursts then remainder, IDs 2,3,0
        send(32'h0, 24'd600, 1'b1, 1'b0);
        wait_valid("l1"); burst("l1", 32'h000, 8'd255, 2'd1, 4'd2, 1'b0, 1'b1); step();
        wait_valid("l2"); burst("l2", 32'h400, 8'd255, 2'd1, 4'd3, 1'b0, 1'b1); step();
        wait_valid("l3"); burst("l3", 32'h800, 8'd87,  2'd1, 4'd0, 1'b1, 1'b1); step();
        wait_ack("cmd2");
        bus.i_cmd_en = 1'b0;
        step();

        // FIXED mode read: same address, capped at 16 beats
        send(32'h2000, 24'd40, 1'b0, 1'b1);
        wait_valid("f1"); burst("f1", 32'h2000, 8'd15, 2'd0, 4'd1, 1'b0, 1'b0); step();
        wait_valid("f2"); burst("f2", 32'h2000, 8'd15, 2'd0, 4'd2, 1'b0, 1'b0); step();
        wait_valid("f3"); burst("f3", 32'h2000, 8'd7,  2'd0, 4'd3, 1'b1, 1'b0); step();
        wait_ack("cmd3");
        bus.i_cmd_en = 1'b0;
        step();

        // Zero count: error with ack at N+2, no descriptor
        send(32'h100, 24'd0, 1'b1, 1'b0);
        step();
        chk("z_n1_ack", 64'(bus.o_cmd_ack), 64'd0);
        chk("z_n1_valid", 64'(bus.o_bst_valid), 64'd0);
        step();
        chk("z_n2_ack", 64'(bus.o_cmd_ack), 64'd1);
        chk("z_n2_err", 64'(bus.o_cmd_error), 64'd1);
        chk("z_n2_valid", 64'(bus.o_bst_valid), 64'd0);
        bus.i_cmd_en = 1'b0;
        step();
        chk("z_ack_clr", 64'(bus.o_cmd_ack), 64'd0);
        chk("z_err_clr", 64'(bus.o_cmd_error), 64'd0);
        chk("z_busy_clr", 64'(bus.o_busy), 64'd0);

        // Backpressure: unaligned address forced to 0x100, held 5 cycles
        bus.i_bst_ready = 1'b0;
        send(32'h0103, 24'd4, 1'b1, 1'b0);
        wait_valid("bp");
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid", 64'(bus.o_bst_valid), 64'd1);
            burst("bp_hold", 32'h0100, 8'd3, 2'd1, 4'd0, 1'b1, 1'b1);
            step();
        end
        hs_before = hs_count;
        bus.i_bst_ready = 1'b1;
        step();
        chk("bp_hs_one", 64'(hs_count), 64'(hs_before + 1));
        wait_ack("bp");
        step(); step();
        chk("bp_hs_total", 64'(hs_count), 64'(hs_before + 1));
        bus.i_cmd_en = 1'b0;
        step();

        // Reset mid-command aborts; ID counter restarts at 0
        send(32'h0, 24'd600, 1'b1, 1'b0);
        wait_valid("r1"); burst("r1", 32'h000, 8'd255, 2'd1, 4'd1, 1'b0, 1'b1); step();
        wait_valid("r2"); burst("r2", 32'h400, 8'd255, 2'd1, 4'd2, 1'b0, 1'b1);
        rst = 1'b1;
        bus.i_cmd_en = 1'b0;
        step();
        all_zero("rst_mid");
        rst = 1'b0;
        step();
        chk("rst_idle_valid", 64'(bus.o_bst_valid), 64'd0);
        send(32'h4, 24'd1, 1'b1, 1'b0);
        wait_valid("p1"); burst("p1", 32'h4, 8'd0, 2'd1, 4'd0, 1'b1, 1'b1); step();
        wait_ack("p1");
        bus.i_cmd_en = 1'b0;
        step();
        chk("p1_busy_clr", 64'(bus.o_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_burst_splitter.md
Name: axi_burst_splitter

Overview:
- Parametrised command front end for the AXI master datapath: accepts one user transfer command (address, beat count, direction, fixed/incr mode) and emits a sequence of legal AXI burst descriptors to the AW/AR issue logic.
- Each burst obeys the AXI max burst length and never crosses the BOUNDARY-byte address boundary.
- Generalises the single fixed-width command path to any DATA_WIDTH, burst limit, boundary and ID pool.
- Assigns AXI IDs round-robin across bursts.

Parameters:
ADDR_WIDTH, 32, address width in bits
DATA_WIDTH, 32, AXI data width; legal values 8..1024, powers of 2; beat size BPB = DATA_WIDTH/8 bytes
COUNT_WIDTH, 24, width of the command beat count
MAX_BURST_LEN, 256, max beats per INCR burst (1..256); FIXED bursts are additionally capped at 16
BOUNDARY, 4096, bytes; no INCR burst may cross a multiple of this (power of 2, >= BPB*2)
ID_WIDTH, 4, width of the AXI ID field
NUM_IDS, 4, number of IDs used round-robin (1..2^ID_WIDTH)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_cmd_en  in  1  command request; held high until o_cmd_ack
i_cmd_addr  in  ADDR_WIDTH  start byte address; low log2(BPB) bits ignored (forced 0)
i_cmd_count  in  COUNT_WIDTH  total beats
i_cmd_wr_rd  in  1  1 = write, 0 = read; copied to every burst
i_cmd_adr_fixed_en  in  1  1 = FIXED burst mode
o_cmd_ack  out  1  all bursts issued; high while i_cmd_en stays high
o_cmd_error  out  1  command rejected (count 0); valid with o_cmd_ack
o_busy  out  1  high from command acceptance until return to IDLE
o_bst_valid  out  1  burst descriptor valid
i_bst_ready  in  1  downstream accepts the descriptor
o_bst_addr  out  ADDR_WIDTH  burst start address (BPB aligned)
o_bst_len  out  8  AXLEN encoding (beats-1)
o_bst_size  out  3  AXSIZE = log2(BPB)
o_bst_burst  out  2  0 = FIXED, 1 = INCR
o_bst_wr_rd  out  1  direction
o_bst_id  out  ID_WIDTH  AXI ID
o_bst_last  out  1  final burst of the command

Behaviour:
- Reset: all outputs 0, except o_bst_size = log2(BPB), which is a constant. State becomes IDLE, ID counter 0. Reset in any state aborts the command; no further descriptors are issued.
- FSM has 4 states: IDLE, CALC, ISSUE, DONE.
- IDLE:
  - On i_cmd_en = 1, latch address (aligned), count, mode and direction, and set o_busy.
  - If count = 0: go to DONE with o_cmd_error = 1. Otherwise go to CALC.
- CALC (1 cycle):
  - INCR: beats = min(remaining, MAX_BURST_LEN, (BOUNDARY - addr mod BOUNDARY)/BPB).
  - FIXED: beats = min(remaining, 16, MAX_BURST_LEN).
  - Register the descriptor and o_bst_last = (beats == remaining). Go to ISSUE.
- ISSUE:
  - o_bst_valid = 1. All descriptor fields stay stable until i_bst_ready = 1.
  - On handshake:
    - remaining -= beats.
    - INCR: addr += beats*BPB, wrapping modulo 2^ADDR_WIDTH. FIXED: addr unchanged.
    - ID counter += 1, wrapping at NUM_IDS.
    - o_bst_valid drops in the next cycle.
    - If remaining == 0, go to DONE; else go to CALC.
- DONE:
  - o_cmd_ack = 1 (o_cmd_error as latched) while i_cmd_en = 1.
  - On i_cmd_en = 0: clear ack/error/busy and go to IDLE.
  - A new command needs i_cmd_en low for at least 1 cycle.
- Latency: i_cmd_en sampled at cycle N gives first o_bst_valid at N+2. With i_bst_ready tied high, one burst is issued per 2 cycles.
- i_cmd_en dropping before ack has no effect; the command runs to completion.
- The ID counter persists across commands (it is not reset per command).
- Arithmetic: remaining is COUNT_WIDTH bits. The beats computation uses COUNT_WIDTH+1 bits so the min is never truncated. o_bst_len = beats-1, truncated to 8 bits (guaranteed ≤ 255).

Decomposition:
- Shared package axi_defines:
  - burst-type constants AXI_BURST_FIXED = 2'b00 and AXI_BURST_INCR = 2'b01;
  - AXI_FIXED_MAX_LEN = 16;
  - the CLOG2 macro;
  - FSM state encodings.
- One sub-module, axi_burst_calc: purely combinational min-of-three beats computation, instantiated in CALC.
- The FSM, registers and ID counter stay in axi_burst_splitter.

Test Plan:
- DATA_WIDTH 32, addr 0x0FF0, count 10, INCR, ready high -> burst 1: addr 0x0FF0, len 3, last 0; burst 2: addr 0x1000, len 5, last 1; ids 0 then 1; then ack.
- addr 0x0, count 600, INCR -> bursts at 0x000/len 255, 0x400/len 255, 0x800/len 87; last only on the third; id wraps 2,3,0 if continuing from id 2.
- FIXED, addr 0x2000, count 40 -> three bursts, all at addr 0x2000, burst = 0, len 15, 15, 7.
- count 0 -> no o_bst_valid; o_cmd_ack and o_cmd_error both 1 at cycle N+2; both clear after i_cmd_en falls.
- i_bst_ready held low 5 cycles in ISSUE -> descriptor fields stable all 5 cycles; exactly one handshake is counted.
- rst asserted during the second burst of the 600-beat case -> next cycle all outputs 0, state IDLE; a new command of count 1 at addr 0x4 issues len 0, id 0.
